// File: rtl/axis_interrupter.sv
// axis_interrupter: AXI-stream register stage that holds beats back for table-programmed gaps.
// Optional AXIS_INTERRUPT_LFSR_EN adds rand_thresh and LFSR-driven random gaps on table misses.
module axis_interrupter #(
  parameter int DATA_W    = 32,
  parameter int N_ENTRIES = 8,
  parameter int BEAT_W    = 16,
  parameter int GAP_W     = 8,
  localparam int AW       = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [BEAT_W-1:0] cfg_beat,
  input  logic [GAP_W-1:0]  cfg_gap,
  input  logic              cfg_clear,
`ifdef AXIS_INTERRUPT_LFSR_EN
  input  logic [7:0]        rand_thresh,
`endif
  input  logic              enable,
  output logic [BEAT_W-1:0] beat_cnt,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, GAP, PASS} state_t;
  state_t r_state, w_state_nxt;
  logic [DATA_W-1:0] r_data;
  logic r_last, r_init, w_s_hs, w_m_hs;
  logic [BEAT_W-1:0] r_cnt, w_cnt_nxt;
  logic [GAP_W-1:0] r_gap, w_gap_nxt, w_tbl_gap, w_load_gap;
  logic [BEAT_W-1:0] r_tbeat [N_ENTRIES];
  logic [GAP_W-1:0] r_tgap [N_ENTRIES];
  assign m_tdata  = r_data;
  assign m_tlast  = r_last;
  assign m_tvalid = r_state == PASS;
  assign beat_cnt = r_cnt;
  assign busy     = r_state != IDLE;
  assign s_tready = r_init && (r_state == IDLE || (r_state == PASS && m_tready));
  assign w_s_hs   = s_tvalid && s_tready;
  assign w_m_hs   = m_tvalid && m_tready;
  // The beat being loaded takes the index after this cycle's output handshake.
  assign w_cnt_nxt = !w_m_hs ? r_cnt : r_last ? '0 : (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  always_comb begin
    w_tbl_gap = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--)
      if (r_tgap[i] != '0 && r_tbeat[i] == w_cnt_nxt) w_tbl_gap = r_tgap[i];
  end
`ifdef AXIS_INTERRUPT_LFSR_EN
  logic [15:0] r_lfsr;
  logic [GAP_W-1:0] w_rand_gap;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) r_lfsr <= 16'hACE1;
    else r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
  assign w_rand_gap = GAP_W'({1'b0, r_lfsr[11:8]} + 5'd1);
  assign w_load_gap = !enable ? '0 : (w_tbl_gap != '0) ? w_tbl_gap :
                      (r_lfsr[7:0] < rand_thresh) ? w_rand_gap : '0;
`else
  assign w_load_gap = enable ? w_tbl_gap : '0;
`endif
  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap;
    if (w_s_hs) begin
      w_state_nxt = (w_load_gap != '0) ? GAP : PASS;
      w_gap_nxt   = w_load_gap;
    end else if (r_state == GAP) begin
      w_state_nxt = (r_gap <= GAP_W'(1)) ? PASS : GAP;
      w_gap_nxt   = r_gap - 1'b1;
    end else if (w_m_hs) begin
      w_state_nxt = IDLE;
    end
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      r_state <= IDLE;
      r_gap   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gap   <= w_gap_nxt;
    end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      r_data <= '0;
      r_last <= 1'b0;
      r_cnt  <= '0;
      r_init <= 1'b0;
    end else begin
      r_init <= 1'b1;
      r_cnt  <= w_cnt_nxt;
      if (w_s_hs) begin
        r_data <= s_tdata;
        r_last <= s_tlast;
      end
    end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        r_tbeat[i] <= '0;
        r_tgap[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_ENTRIES; i++)
        if (cfg_clear) r_tgap[i] <= '0;
        else if (cfg_we && cfg_addr == AW'(i)) begin
          r_tbeat[i] <= cfg_beat;
          r_tgap[i]  <= cfg_gap;
        end
    end
endmodule

// File: tb/tb_axis_interrupter.sv
// tb_axis_interrupter: directed vector table plus multi-cycle sequences for axis_interrupter.
module tb_axis_interrupter;
  logic clk = 1'b0, aresetn = 1'b0;
  logic [31:0] s_tdata = '0, m_tdata;
  logic s_tvalid = 1'b0, s_tlast = 1'b0, s_tready, m_tvalid, m_tlast, m_tready = 1'b0;
  logic cfg_we = 1'b0, cfg_clear = 1'b0, enable = 1'b0, busy;
  logic [2:0] cfg_addr = '0;
  logic [15:0] cfg_beat = '0, beat_cnt;
  logic [7:0] cfg_gap = '0;
`ifdef AXIS_INTERRUPT_LFSR_EN
  logic [7:0] rand_thresh = '0;
`endif
  int n_vec = 0, n_err = 0;
  int lows [32];

  axis_interrupter dut (
    .aclk(clk), .aresetn(aresetn),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_beat(cfg_beat), .cfg_gap(cfg_gap),
    .cfg_clear(cfg_clear),
`ifdef AXIS_INTERRUPT_LFSR_EN
    .rand_thresh(rand_thresh),
`endif
    .enable(enable), .beat_cnt(beat_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic en, sv; logic [31:0] sd; logic sl, mr;
    logic e_sr, e_mv; logic [31:0] e_md; logic e_ml; logic [15:0] e_cnt; logic e_busy;
  } vec_t;
  vec_t vt [11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [15:0] b, input logic [7:0] g);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = a; cfg_beat = b; cfg_gap = g;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic cfg_clr();
    @(posedge clk); #1;
    cfg_clear = 1'b1;
    @(posedge clk); #1;
    cfg_clear = 1'b0;
  endtask

  // Streams n beats; records low-valid cycles preceding each output beat in lows[].
  task automatic run_pkt(input int n, input logic [31:0] base, input logic tog);
    int sent = 0, got = 0, low = 0, cyc = 0;
    logic held = 1'b0;
    logic [31:0] hd = '0, ed;
    for (int i = 0; i < 32; i++) lows[i] = 0;
    while (got < n && cyc < 400) begin
      @(posedge clk); #1;
      s_tvalid = sent < n; s_tdata = base + 32'(sent); s_tlast = sent == n - 1;
      m_tready = tog ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk);
      if (held) chk("hold_stable", 64'({m_tvalid, m_tdata}), 64'({1'b1, hd}));
      held = m_tvalid && !m_tready;
      hd = m_tdata;
      if (m_tvalid && m_tready) begin
        ed = base + 32'(got);
        chk($sformatf("beat%0d", got), 64'({m_tlast, beat_cnt, m_tdata}),
            64'({got == n - 1, got[15:0], ed}));
        lows[got] = low;
        got++;
        low = 0;
      end else if (!m_tvalid) low++;
      if (s_tvalid && s_tready) sent++;
      cyc++;
    end
    chk("pkt_complete", 64'(got), 64'(n));
    s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
  endtask

  initial begin
    int lw, sum;
    logic done;
    vt[0]  = '{1'b1, 1'b1, 32'hA0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 16'd0, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 32'hA1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA0, 1'b0, 16'd0, 1'b1};
    vt[2]  = '{1'b1, 1'b1, 32'hA2, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 16'd1, 1'b1};
    vt[3]  = '{1'b1, 1'b1, 32'hA2, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 16'd1, 1'b1};
    vt[4]  = '{1'b1, 1'b1, 32'hA2, 1'b1, 1'b1, 1'b1, 1'b1, 32'hA1, 1'b0, 16'd1, 1'b1};
    vt[5]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 32'hA2, 1'b1, 16'd2, 1'b1};
    vt[6]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b1, 32'hA2, 1'b1, 16'd2, 1'b1};
    vt[7]  = '{1'b0, 1'b1, 32'hB0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 16'd0, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 32'hB1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hB0, 1'b0, 16'd0, 1'b1};
    vt[9]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b1, 32'hB1, 1'b1, 16'd1, 1'b1};
    vt[10] = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 16'd0, 1'b0};

    #1;
    chk("reset_state", 64'({s_tready, m_tvalid, m_tlast, m_tdata, beat_cnt, busy}), 64'(0));
    repeat (3) @(posedge clk);
    @(negedge clk); aresetn = 1'b1;
    @(posedge clk); #1;
    chk("tready_after_release", 64'(s_tready), 64'(1));

    for (int k = 0; k < 18; k++) begin
      @(posedge clk); #1;
      enable = 1'b0; m_tready = 1'b1;
      s_tvalid = k < 16; s_tdata = 32'(100 + k); s_tlast = k == 15;
      @(negedge clk);
      if (k == 0) chk("stream_latency", 64'(m_tvalid), 64'(0));
      else if (k <= 16)
        chk($sformatf("stream%0d", k - 1), 64'({s_tready, m_tvalid, m_tlast, beat_cnt, m_tdata}),
            64'({1'b1, 1'b1, k == 16, 16'(k - 1), 32'(100 + k - 1)}));
      else chk("stream_wrap", 64'({m_tvalid, beat_cnt}), 64'(0));
    end

    cfg_write(3'd0, 16'd1, 8'd2);
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      enable = vt[i].en; s_tvalid = vt[i].sv; s_tdata = vt[i].sd; s_tlast = vt[i].sl;
      m_tready = vt[i].mr;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          64'({s_tready, m_tvalid, vt[i].e_mv ? m_tdata : 32'h0, vt[i].e_mv & m_tlast, beat_cnt, busy}),
          64'({vt[i].e_sr, vt[i].e_mv, vt[i].e_md, vt[i].e_ml, vt[i].e_cnt, vt[i].e_busy}));
    end

    enable = 1'b1;
    cfg_clr();
    cfg_write(3'd0, 16'd3, 8'd5);
    run_pkt(8, 32'd200, 1'b0);
    sum = lows[1] + lows[2] + lows[4] + lows[5] + lows[6] + lows[7];
    chk("gap5_before_beat3", 64'({8'(lows[0]), 8'(lows[3]), 8'(sum)}), 64'({8'd1, 8'd5, 8'd0}));

    @(posedge clk); #1;
    cfg_clear = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd2; cfg_beat = 16'd1; cfg_gap = 8'd4;
    @(posedge clk); #1;
    cfg_clear = 1'b0; cfg_we = 1'b0;
    run_pkt(3, 32'd250, 1'b0);
    chk("clear_beats_we", 64'({8'(lows[0]), 8'(lows[1]), 8'(lows[2])}), 64'({8'd1, 8'd0, 8'd0}));

    cfg_write(3'd1, 16'd0, 8'd2);
    cfg_write(3'd4, 16'd0, 8'd7);
    run_pkt(3, 32'd300, 1'b0);
    chk("lowest_addr_wins", 64'({8'(lows[0]), 8'(lows[1]), 8'(lows[2])}), 64'({8'd3, 8'd0, 8'd0}));

    cfg_clr();
    cfg_write(3'd0, 16'd0, 8'd4);
    @(posedge clk); #1;
    s_tvalid = 1'b1; s_tdata = 32'd700; s_tlast = 1'b1; m_tready = 1'b1;
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0; enable = 1'b0;
    lw = 0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (m_tvalid) done = 1'b1;
      else lw++;
    end
    chk("gap_survives_disable", 64'({8'(lw), m_tdata}), 64'({8'd4, 32'd700}));
    @(posedge clk); #1;
    enable = 1'b1;

    cfg_clr();
    cfg_write(3'd2, 16'd2, 8'd3);
    run_pkt(6, 32'd400, 1'b1);

    cfg_clr();
    cfg_write(3'd0, 16'd1, 8'd5);
    @(posedge clk); #1;
    s_tvalid = 1'b1; s_tdata = 32'd500; s_tlast = 1'b0; m_tready = 1'b1;
    @(posedge clk); #1;
    s_tdata = 32'd501; s_tlast = 1'b1;
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
    @(negedge clk);
    chk("in_gap_pre_reset", 64'({m_tvalid, busy, beat_cnt}), 64'({1'b0, 1'b1, 16'd1}));
    @(posedge clk); #1;
    @(negedge clk); aresetn = 1'b0; #1;
    chk("reset_mid_gap", 64'({s_tready, m_tvalid, busy, beat_cnt, m_tdata}), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk); aresetn = 1'b1;
    @(posedge clk); #1;
    chk("tready_after_rerelease", 64'(s_tready), 64'(1));
    run_pkt(4, 32'd600, 1'b0);
    chk("table_cleared", 64'({8'(lows[0]), 8'(lows[1] + lows[2] + lows[3])}), 64'({8'd1, 8'd0}));

`ifdef AXIS_INTERRUPT_LFSR_EN
    rand_thresh = 8'd255;
    run_pkt(4, 32'd800, 1'b0);
    done = lows[0] >= 2 && lows[0] <= 17;
    for (int i = 1; i < 4; i++) done = done && lows[i] >= 1 && lows[i] <= 16;
    chk("lfsr_gaps_all", 64'(done), 64'(1));
    rand_thresh = 8'd0;
    run_pkt(4, 32'd900, 1'b0);
    chk("lfsr_gaps_none", 64'({8'(lows[0]), 8'(lows[1] + lows[2] + lows[3])}), 64'({8'd1, 8'd0}));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
